// File: rtl/fir_channel_scheduler_pkg.sv
// Shared types and defaults for the FIR channel scheduler.
package fir_sched_pkg;

  localparam int unsigned NUM_CH_DEF    = 3;
  localparam int unsigned TAG_DEPTH_DEF = 4;
  localparam int unsigned CH_ID_W       = (NUM_CH_DEF > 1) ? $clog2(NUM_CH_DEF) : 1;

  typedef logic [CH_ID_W-1:0] ch_id_t;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/fir_channel_scheduler_if.sv
// AXI-stream links between the scheduler and the shared FIR.
interface fir_channel_scheduler_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic              fir_s_tvalid;
  logic              fir_s_tready;
  logic [DATA_W-1:0] fir_s_tdata;
  logic              fir_m_tvalid;
  logic [DATA_W-1:0] fir_m_tdata;

  modport master (
    output fir_s_tvalid,
    output fir_s_tdata,
    input  fir_s_tready,
    input  fir_m_tvalid,
    input  fir_m_tdata
  );

  modport slave (
    input  fir_s_tvalid,
    input  fir_s_tdata,
    output fir_s_tready,
    output fir_m_tvalid,
    output fir_m_tdata
  );
endinterface

// File: rtl/fir_channel_scheduler_tag_fifo.sv
// Channel-id FIFO tracking FIR samples in flight; push and pop may coincide even when full.
module tag_fifo
  import fir_sched_pkg::*;
#(
  parameter int unsigned DEPTH = TAG_DEPTH_DEF
) (
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   push,
  input  ch_id_t push_tag,
  input  logic   pop,
  output ch_id_t pop_tag_c,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  ch_id_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign pop_tag_c = mem[rd_ptr];
  assign count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);

  // Tag storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler sharing one FIR across NUM_CH mic channels.
// Optional per-channel handshake counters: define FIR_SCHED_STATS_EN.
module fir_channel_scheduler
  import fir_sched_pkg::*;
#(
  parameter int unsigned NUM_CH    = NUM_CH_DEF,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_CH-1:0]        sample_valid_in,
  input  logic [NUM_CH*DATA_W-1:0] sample_in,
  fir_channel_scheduler_if.master  fir,
  output logic [NUM_CH-1:0]        filt_valid_out,
  output logic [NUM_CH*DATA_W-1:0] filt_out,
  output logic [NUM_CH-1:0]        overrun_out,
  output logic                     tag_err_out
`ifdef FIR_SCHED_STATS_EN
  ,
  output logic [NUM_CH*16-1:0]     stat_count_out
`endif
);

  fsm_state_t        state;
  fsm_state_t        state_nxt;
  logic              grant_c;
  ch_id_t            grant_ch_c;
  ch_id_t            last_grant;
  ch_id_t            cur_ch;
  logic [NUM_CH-1:0] pending;
  logic [DATA_W-1:0] pending_data [NUM_CH];
  logic              push_c;
  logic              pop_c;
  logic              tag_full;
  logic              tag_empty;
  ch_id_t            pop_tag_c;

  assign push_c = (state == OFFER) && fir.fir_s_tready;
  assign pop_c  = fir.fir_m_tvalid && !tag_empty;

  tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (push_c),
    .push_tag  (cur_ch),
    .pop       (pop_c),
    .pop_tag_c (pop_tag_c),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and round-robin pick; the descending loop lets the nearest channel after last_grant win.
  always_comb begin
    state_nxt  = state;
    grant_c    = 1'b0;
    grant_ch_c = last_grant;
    for (int i = int'(NUM_CH); i >= 1; i--) begin
      if (pending[ch_id_t'((int'(last_grant) + i) % int'(NUM_CH))])
        grant_ch_c = ch_id_t'((int'(last_grant) + i) % int'(NUM_CH));
    end
    case (state)
      IDLE: begin
        if ((|pending) && !tag_full) begin
          state_nxt = OFFER;
          grant_c   = 1'b1;
        end
      end
      OFFER: begin
        if (fir.fir_s_tready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pending capture, overrun detection and FIR input offer.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pending          <= '0;
      overrun_out      <= '0;
      last_grant       <= ch_id_t'(NUM_CH - 1);
      cur_ch           <= '0;
      fir.fir_s_tvalid <= 1'b0;
      fir.fir_s_tdata  <= '0;
      for (int c = 0; c < int'(NUM_CH); c++) pending_data[c] <= '0;
    end else begin
      fir.fir_s_tvalid <= (state_nxt == OFFER);
      if (grant_c) begin
        fir.fir_s_tdata <= pending_data[grant_ch_c];
        last_grant      <= grant_ch_c;
        cur_ch          <= grant_ch_c;
      end
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (sample_valid_in[c]) begin
          pending_data[c] <= sample_in[c*DATA_W +: DATA_W];
          pending[c]      <= 1'b1;
          if (pending[c] && !(grant_c && (grant_ch_c == ch_id_t'(c))))
            overrun_out[c] <= 1'b1;
        end else if (grant_c && (grant_ch_c == ch_id_t'(c))) begin
          pending[c] <= 1'b0;
        end
      end
    end
  end

  // Route FIR results back to their channel; orphan results raise tag_err_out.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      filt_valid_out <= '0;
      filt_out       <= '0;
      tag_err_out    <= 1'b0;
    end else begin
      filt_valid_out <= '0;
      if (fir.fir_m_tvalid && tag_empty) tag_err_out <= 1'b1;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (pop_c && (pop_tag_c == ch_id_t'(c))) begin
          filt_valid_out[c]            <= 1'b1;
          filt_out[c*DATA_W +: DATA_W] <= fir.fir_m_tdata;
        end
      end
    end
  end

`ifdef FIR_SCHED_STATS_EN
  // Wrapping per-channel count of accepted FIR input samples.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_count_out <= '0;
    end else if (push_c) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (cur_ch == ch_id_t'(c))
          stat_count_out[c*16 +: 16] <= stat_count_out[c*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed scoreboard bench for fir_channel_scheduler with an echoing FIR model.
module tb_fir_channel_scheduler;
  import fir_sched_pkg::*;

  localparam int unsigned NUM_CH   = 3;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ECHO_DLY = 5;

  typedef struct packed {
    ch_id_t      ch;
    logic [15:0] data;
  } hs_t;

  typedef struct packed {
    ch_id_t      ch;
    logic [15:0] data;
    logic [31:0] due;
  } fir_t;

  logic                     clk_in = 1'b0;
  logic                     rst_in;
  logic [NUM_CH-1:0]        sample_valid_in;
  logic [NUM_CH*DATA_W-1:0] sample_in;
  logic [NUM_CH-1:0]        filt_valid_out;
  logic [NUM_CH*DATA_W-1:0] filt_out;
  logic [NUM_CH-1:0]        overrun_out;
  logic                     tag_err_out;
`ifdef FIR_SCHED_STATS_EN
  logic [NUM_CH*16-1:0]     stat_count_out;
`endif

  fir_channel_scheduler_if #(.DATA_W(DATA_W)) fir ();

  fir_channel_scheduler #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .TAG_DEPTH (4)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sample_valid_in (sample_valid_in),
    .sample_in       (sample_in),
    .fir             (fir),
    .filt_valid_out  (filt_valid_out),
    .filt_out        (filt_out),
    .overrun_out     (overrun_out),
    .tag_err_out     (tag_err_out)
`ifdef FIR_SCHED_STATS_EN
    ,
    .stat_count_out  (stat_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int                       errors;
  int                       checks;
  hs_t                      exp_hs [$];
  fir_t                     fir_q [$];
  logic [31:0]              cyc;
  logic                     fir_hold;
  logic                     orphan_req;
  logic                     pend_filt;
  ch_id_t                   pend_ch;
  logic [15:0]              pend_data;
  int                       hs_cnt;
  int                       filt_pulses [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] filt_model;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input ch_id_t ch, input logic [15:0] d);
    hs_t e;
    e.ch   = ch;
    e.data = d;
    exp_hs.push_back(e);
  endtask

  // One clock: check at negedge, drive the FIR model, then return #1 after posedge.
  task automatic tick();
    hs_t               e;
    fir_t              f;
    logic [NUM_CH-1:0] exp_vec;
    @(negedge clk_in);
    if (!rst_in) begin
      exp_vec = '0;
      if (pend_filt) exp_vec[pend_ch] = 1'b1;
      if (pend_filt || (filt_valid_out != '0)) begin
        chk("filt_valid", 64'(filt_valid_out), 64'(exp_vec));
        if (pend_filt) begin
          filt_model[int'(pend_ch)*DATA_W +: DATA_W] = pend_data;
          chk("filt_out", 64'(filt_out), 64'(filt_model));
        end
      end
      for (int c = 0; c < int'(NUM_CH); c++)
        if (filt_valid_out[c]) filt_pulses[c]++;
      if (fir.fir_s_tvalid && fir.fir_s_tready) begin
        hs_cnt++;
        if (exp_hs.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL hs_unexpected: got tdata %0h required no handshake", fir.fir_s_tdata);
        end else begin
          e = exp_hs.pop_front();
          chk("hs_data", 64'(fir.fir_s_tdata), 64'(e.data));
          f.ch   = e.ch;
          f.data = e.data;
          f.due  = cyc + ECHO_DLY;
          fir_q.push_back(f);
        end
      end
    end
    pend_filt        = 1'b0;
    fir.fir_m_tvalid = 1'b0;
    if (!fir_hold && (fir_q.size() > 0) && (fir_q[0].due <= cyc)) begin
      f                = fir_q.pop_front();
      fir.fir_m_tvalid = 1'b1;
      fir.fir_m_tdata  = f.data;
      pend_filt        = 1'b1;
      pend_ch          = f.ch;
      pend_data        = f.data;
    end else if (orphan_req) begin
      fir.fir_m_tvalid = 1'b1;
      fir.fir_m_tdata  = 16'hDEAD;
      orphan_req       = 1'b0;
    end
    @(posedge clk_in);
    cyc = cyc + 32'd1;
    #1;
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] mask, input logic [NUM_CH*DATA_W-1:0] d);
    sample_valid_in = mask;
    sample_in       = d;
    tick();
    sample_valid_in = '0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (((exp_hs.size() != 0) || (fir_q.size() != 0) || pend_filt) && (n < budget)) begin
      tick();
      n++;
    end
    chk(tag, 64'(exp_hs.size() + fir_q.size() + int'(pend_filt)), 64'(0));
  endtask

  task automatic wait_hs(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_hs.size() != 0) && (n < budget)) begin
      tick();
      n++;
    end
    chk(tag, 64'(exp_hs.size()), 64'(0));
  endtask

  task automatic clear_model();
    exp_hs.delete();
    fir_q.delete();
    pend_filt  = 1'b0;
    fir_hold   = 1'b0;
    orphan_req = 1'b0;
    filt_model = '0;
    hs_cnt     = 0;
    for (int c = 0; c < int'(NUM_CH); c++) filt_pulses[c] = 0;
  endtask

  task automatic apply_reset();
    rst_in          = 1'b1;
    sample_valid_in = '0;
    clear_model();
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  initial begin
    errors           = 0;
    checks           = 0;
    cyc              = '0;
    rst_in           = 1'b1;
    sample_valid_in  = '0;
    sample_in        = '0;
    fir.fir_s_tready = 1'b0;
    fir.fir_m_tvalid = 1'b0;
    fir.fir_m_tdata  = '0;
    clear_model();
    apply_reset();

    // Reset state
    chk("rst_tvalid", 64'(fir.fir_s_tvalid), 64'(0));
    chk("rst_filt_valid", 64'(filt_valid_out), 64'(0));
    chk("rst_filt_out", 64'(filt_out), 64'(0));
    chk("rst_overrun", 64'(overrun_out), 64'(0));
    chk("rst_tag_err", 64'(tag_err_out), 64'(0));

    // Single sample on ch0, FIR echoes after ECHO_DLY cycles
    fir.fir_s_tready = 1'b1;
    push_exp(2'd0, 16'h1234);
    pulse(3'b001, {32'h0, 16'h1234});
    chk("lat_e1_tvalid", 64'(fir.fir_s_tvalid), 64'(0));
    tick();
    chk("lat_e2_tvalid", 64'(fir.fir_s_tvalid), 64'(1));
    chk("lat_e2_tdata", 64'(fir.fir_s_tdata), 64'h1234);
    drain("s1_drain", 40);
    chk("s1_filt0", 64'(filt_out[15:0]), 64'h1234);
    chk("s1_pulses0", 64'(filt_pulses[0]), 64'(1));

    // All channels at once: served ch0, ch1, ch2
    apply_reset();
    fir.fir_s_tready = 1'b1;
    push_exp(2'd0, 16'hA001);
    push_exp(2'd1, 16'hB002);
    push_exp(2'd2, 16'hC003);
    pulse(3'b111, {16'hC003, 16'hB002, 16'hA001});
    drain("s2_drain", 60);
    chk("s2_pulses", 64'({filt_pulses[2][7:0], filt_pulses[1][7:0], filt_pulses[0][7:0]}), 64'h010101);
    chk("s2_filt_all", 64'(filt_out), 64'({16'hC003, 16'hB002, 16'hA001}));

    // New sample on the channel being granted keeps it pending without overrun
    push_exp(2'd0, 16'h0D01);
    pulse(3'b001, {32'h0, 16'h0D01});
    push_exp(2'd0, 16'h0D02);
    pulse(3'b001, {32'h0, 16'h0D02});
    drain("s2b_drain", 60);
    chk("s2b_overrun", 64'(overrun_out), 64'(0));

    // FIR stalled: ch1 pulsed twice while ch0 is offered
    apply_reset();
    fir.fir_s_tready = 1'b0;
    push_exp(2'd0, 16'h0A0A);
    pulse(3'b001, {32'h0, 16'h0A0A});
    tick();
    pulse(3'b010, {16'h0, 16'h1111, 16'h0});
    push_exp(2'd1, 16'h2222);
    pulse(3'b010, {16'h0, 16'h2222, 16'h0});
    repeat (6) tick();
    chk("s3_overrun", 64'(overrun_out), 64'b010);
    chk("s3_stable_tvalid", 64'(fir.fir_s_tvalid), 64'(1));
    chk("s3_stable_tdata", 64'(fir.fir_s_tdata), 64'h0A0A);
    fir.fir_s_tready = 1'b1;
    drain("s3_drain", 60);
    chk("s3_overrun_sticky", 64'(overrun_out), 64'b010);

    // Tag FIFO full blocks the fifth offer until one FIR result returns
    apply_reset();
    fir.fir_s_tready = 1'b1;
    fir_hold         = 1'b1;
    push_exp(2'd0, 16'h0111);
    push_exp(2'd1, 16'h0222);
    push_exp(2'd2, 16'h0333);
    pulse(3'b111, {16'h0333, 16'h0222, 16'h0111});
    wait_hs("s4_wait3", 40);
    push_exp(2'd0, 16'h0444);
    pulse(3'b001, {32'h0, 16'h0444});
    wait_hs("s4_wait4", 40);
    push_exp(2'd1, 16'h0555);
    pulse(3'b010, {16'h0, 16'h0555, 16'h0});
    repeat (8) tick();
    chk("s4_hs_cnt_full", 64'(hs_cnt), 64'(4));
    chk("s4_no_offer", 64'(fir.fir_s_tvalid), 64'(0));
    fir_hold = 1'b0;
    drain("s4_drain", 80);
    chk("s4_hs_cnt_after", 64'(hs_cnt), 64'(5));

    // FIR result with no outstanding tag
    apply_reset();
    orphan_req = 1'b1;
    repeat (3) tick();
    chk("s5_tag_err", 64'(tag_err_out), 64'(1));
    chk("s5_filt_valid", 64'(filt_valid_out), 64'(0));
    chk("s5_no_pulses", 64'(filt_pulses[0] + filt_pulses[1] + filt_pulses[2]), 64'(0));

    // Reset in the middle of an offer
    fir.fir_s_tready = 1'b0;
    pulse(3'b001, {32'h0, 16'h0606});
    tick();
    chk("s6_offer_tvalid", 64'(fir.fir_s_tvalid), 64'(1));
    pulse(3'b001, {32'h0, 16'h0707});
    pulse(3'b001, {32'h0, 16'h0808});
    chk("s6_pre_overrun", 64'(overrun_out), 64'b001);
    rst_in = 1'b1;
    clear_model();
    tick();
    chk("s6_rst_tvalid", 64'(fir.fir_s_tvalid), 64'(0));
    chk("s6_rst_overrun", 64'(overrun_out), 64'(0));
    chk("s6_rst_tag_err", 64'(tag_err_out), 64'(0));
    chk("s6_rst_filt_valid", 64'(filt_valid_out), 64'(0));
    tick();
    rst_in           = 1'b0;
    fir.fir_s_tready = 1'b1;
    repeat (4) tick();
    chk("s6_no_stale_offer", 64'(hs_cnt), 64'(0));

`ifdef FIR_SCHED_STATS_EN
    // Per-channel handshake counters
    apply_reset();
    fir.fir_s_tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_exp(2'd2, 16'h2000 + 16'(k));
      pulse(3'b100, {16'h2000 + 16'(k), 32'h0});
      wait_hs("st_wait", 40);
    end
    drain("st_drain", 60);
    chk("st_ch2_count", 64'(stat_count_out[47:32]), 64'(3));
    chk("st_ch01_count", 64'(stat_count_out[31:0]), 64'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_channel_scheduler.md
FIR_CHANNEL_SCHEDULER -- requirements
Module: fir_channel_scheduler

Interface
REQ-001 Parameter NUM_CH, default 3: number of mic channels sharing one anti-alias FIR.
REQ-002 Parameter DATA_W, default 16: signed sample width.
REQ-003 Parameter TAG_DEPTH, default 4, power of two: maximum FIR samples in flight.
REQ-004 clk_in  input  1: sole clock (audio clock domain).
REQ-005 rst_in  input  1: synchronous, active-high reset.
REQ-006 sample_valid_in  input  NUM_CH: one-cycle valid pulse per channel, from the i2s receivers.
REQ-007 sample_in  input  NUM_CH*DATA_W: per-channel samples, with ch0 in the LSBs.
REQ-008 fir_s_tvalid  output  1: AXI-stream valid to the FIR input.
REQ-009 fir_s_tready  input  1: FIR input ready.
REQ-010 fir_s_tdata  output  DATA_W: FIR input sample.
REQ-011 fir_m_tvalid  input  1: FIR output valid. The FIR output is never back-pressured.
REQ-012 fir_m_tdata  input  DATA_W: FIR output sample.
REQ-013 filt_valid_out  output  NUM_CH: one-cycle pulse per channel when a filtered sample updates.
REQ-014 filt_out  output  NUM_CH*DATA_W: last filtered sample per channel, with ch0 in the LSBs.
REQ-015 overrun_out  output  NUM_CH: sticky flag, set when a pending sample is overwritten.
REQ-016 tag_err_out  output  1: sticky flag, set on FIR output with no outstanding tag.

Function
REQ-017 A sample_valid_in[c] pulse shall load sample_in[c] into pending_data[c] and set pending[c] at that edge.
REQ-018 A valid pulse while pending[c] is set and c is not being granted in the same cycle shall overwrite the pending data and set overrun_out[c].
REQ-019 The FSM shall have two states: IDLE (fir_s_tvalid=0) and OFFER (fir_s_tvalid=1).
REQ-020 The IDLE->OFFER transition shall occur when any pending bit is set and the tag FIFO is not full.
  - The grant goes to the first pending channel after last_grant, round-robin modulo NUM_CH.
  - At the grant, fir_s_tdata is registered from that channel's pending data, its pending bit is cleared, and last_grant is updated.
REQ-021 A valid pulse arriving on the granted channel in the grant cycle shall leave pending set with the new data, without setting overrun.
REQ-022 In OFFER, fir_s_tvalid and fir_s_tdata shall stay stable until fir_s_tready=1.
  - On that handshake, push the granted channel id into the tag FIFO and return to IDLE.
  - No back-to-back offer is made; the sustained rate is one sample per 2 cycles, which is ample at 48 kHz.
REQ-023 Minimum latency shall be 2 edges: a sample_valid_in edge leads to fir_s_tvalid high 1 edge later, when the FIR is ready and the channel wins arbitration.
REQ-024 On fir_m_tvalid=1 with a non-empty FIFO, pop tag c.
  - filt_out[c] <= fir_m_tdata and filt_valid_out[c]=1 on the next edge.
  - All other channels hold their value, with valid=0.
REQ-025 A simultaneous push and pop shall be legal at any occupancy, including full; the occupancy is then unchanged.
REQ-026 fir_m_tvalid with an empty FIFO shall drop the data, set tag_err_out, and produce no filt_valid_out.
REQ-027 When the FIFO is full, there shall be no new grant; pending samples wait and may overrun per REQ-018.

Reset
REQ-028 On rst_in, the following shall clear: all outputs, pending bits, sticky flags, and the tag FIFO. The FSM returns to IDLE and last_grant is set to NUM_CH-1, so ch0 wins first.
REQ-029 A reset during OFFER shall drop fir_s_tvalid at the next edge. FIR outputs still in flight after reset are reported through REQ-026.

Configuration
REQ-030 With macro FIR_SCHED_STATS_EN defined, the block shall add output stat_count_out, NUM_CH*16 bits, with one wrapping counter per channel.
  - Each counter increments on that channel's fir_s handshake.
  - Each counter clears on reset.
REQ-031 Without FIR_SCHED_STATS_EN, the stat_count_out port and its counters shall be absent, and all other behaviour is identical.

Structure
REQ-032 The NUM_CH and TAG_DEPTH defaults, the channel-id typedef (width $clog2(NUM_CH)) and the FSM state enum shall live in package fir_sched_pkg.
REQ-033 The tag FIFO shall be a separate sub-module tag_fifo.
  - Synchronous; push, pop, full and empty signals; depth TAG_DEPTH.
  - Width equal to the channel-id typedef.

Verification
REQ-034 A bench shall cover: ch0 pulse with 16'h1234, ready=1, FIR echoing after 5 cycles -> tvalid 1 edge later with tdata 16'h1234; filt_out[0]=16'h1234 with filt_valid_out[0] pulsed once.
REQ-035 A bench shall cover: all 3 channels pulsed in the same cycle -> handshakes in order ch0, ch1, ch2, and each filt_out matches its source channel.
REQ-036 A bench shall cover: ready held 0 for 10 cycles, then ch1 pulsed twice -> overrun_out=3'b010, and only the second value is sent.
REQ-037 A bench shall cover: FIR output withheld until 4 handshakes -> the 5th pending sample is not offered; one fir_m_tvalid pop -> the next offer issues.
REQ-038 A bench shall cover: fir_m_tvalid with no outstanding tag -> tag_err_out=1 and filt_valid_out stays 0.
REQ-039 A bench shall cover: reset asserted mid-OFFER -> tvalid low next edge and all flags 0; with FIR_SCHED_STATS_EN, 3 ch2 handshakes -> ch2 count=3.
